// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester SDRAM block arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_e;

  localparam logic RQ_IMG = 1'b0;
  localparam logic RQ_SD  = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Two-way winner selector for ram_arbiter: round-robin on ties by default,
// fixed rq0 priority when RAM_ARB_FIXED_PRIORITY_EN is defined.
module ram_arb_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

`ifdef RAM_ARB_FIXED_PRIORITY_EN
  // last only shapes the no-request case, where the winner is never used
  assign winner = !req[0] && (req[1] || last);
`else
  assign winner = (req == 2'b11) ? !last : req[1];
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Block-level arbiter sharing one SDRAM controller port between the image
// writer (rq0) and SD reader (rq1). Tie policy set by RAM_ARB_FIXED_PRIORITY_EN.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BLOCK_W     = 10,
  parameter int unsigned BLOCK_WORDS = 256
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               rq0_req,
  input  logic               rq0_write,
  input  logic [BLOCK_W-1:0] rq0_block,
  output logic               rq0_grant,
  input  logic [DATA_W-1:0]  rq0_wdata,
  input  logic               rq0_wvalid,
  output logic               rq0_wready,
  output logic [DATA_W-1:0]  rq0_rdata,
  output logic               rq0_rvalid,
  output logic               rq0_done,
  input  logic               rq1_req,
  input  logic               rq1_write,
  input  logic [BLOCK_W-1:0] rq1_block,
  output logic               rq1_grant,
  input  logic [DATA_W-1:0]  rq1_wdata,
  input  logic               rq1_wvalid,
  output logic               rq1_wready,
  output logic [DATA_W-1:0]  rq1_rdata,
  output logic               rq1_rvalid,
  output logic               rq1_done,
  output logic               ram_cmd_valid,
  input  logic               ram_cmd_ready,
  output logic               ram_cmd_write,
  output logic [BLOCK_W-1:0] ram_cmd_block,
  output logic [DATA_W-1:0]  ram_wdata,
  output logic               ram_wvalid,
  input  logic               ram_wready,
  input  logic [DATA_W-1:0]  ram_rdata,
  input  logic               ram_rvalid,
  output logic               busy
);

  localparam int unsigned         CNT_W     = cnt_width(BLOCK_WORDS);
  localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);

  state_e             state_q, state_d;
  logic               win_q, win_d;
  logic               write_q, write_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         done_q, done_d;

  logic pick_win;
  logic wr_phase, rd_phase, sel_wvalid, beat;

  ram_arb_pick u_pick (
    .req    ({rq1_req, rq0_req}),
    .last   (last_q),
    .winner (pick_win)
  );

  assign wr_phase   = (state_q == DATA) && write_q;
  assign rd_phase   = (state_q == DATA) && !write_q;
  assign sel_wvalid = (win_q == RQ_SD) ? rq1_wvalid : rq0_wvalid;

  assign ram_wvalid = wr_phase && sel_wvalid;
  assign ram_wdata  = wr_phase ? ((win_q == RQ_SD) ? rq1_wdata : rq0_wdata) : '0;
  assign rq0_wready = wr_phase && (win_q == RQ_IMG) && ram_wready;
  assign rq1_wready = wr_phase && (win_q == RQ_SD) && ram_wready;
  assign rq0_rvalid = rd_phase && (win_q == RQ_IMG) && ram_rvalid;
  assign rq1_rvalid = rd_phase && (win_q == RQ_SD) && ram_rvalid;
  assign rq0_rdata  = ram_rdata;
  assign rq1_rdata  = ram_rdata;

  assign beat = wr_phase ? (sel_wvalid && ram_wready) : (rd_phase && ram_rvalid);

  assign rq0_grant     = grant_q[0];
  assign rq1_grant     = grant_q[1];
  assign rq0_done      = done_q[0];
  assign rq1_done      = done_q[1];
  assign ram_cmd_valid = (state_q == CMD);
  assign ram_cmd_write = write_q;
  assign ram_cmd_block = block_q;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    write_d = write_q;
    block_d = block_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = '0;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (rq0_req || rq1_req) begin
          win_d   = pick_win;
          write_d = (pick_win == RQ_SD) ? rq1_write : rq0_write;
          block_d = (pick_win == RQ_SD) ? rq1_block : rq0_block;
          grant_d = (pick_win == RQ_SD) ? 2'b10 : 2'b01;
          state_d = CMD;
        end
      end
      CMD: begin
        if (ram_cmd_ready) state_d = DATA;
      end
      DATA: begin
        if (beat) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            done_d  = (win_q == RQ_SD) ? 2'b10 : 2'b01;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        last_d  = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      win_q   <= RQ_IMG;
      write_q <= 1'b0;
      block_q <= '0;
      cnt_q   <= '0;
      last_q  <= RQ_SD;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      write_q <= write_d;
      block_q <= block_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      done_q  <= done_d;
    end
  end

endmodule
